mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the segmented memory's single data port between the pipeline MEM stage (requester P) and the IO/DMA copy engine (requester D). It drives the memory's data-side controls (`we`, `a2`, `wd`), returns the one-cycle-late read data to the winning requester, and stalls P while D holds the port. It also owns the sticky `startIO` flag that the memory exposes at address RAMSIZE*7.

## Interface
- `WIDTH`, 32, data and address width
- `RAMSIZE`, 1024, memory base unit; the IO flag address is RAMSIZE*7
- `MAXWAIT`, 8, consecutive D denials before the aging guard forces a D grant (guard build only)

- `clk` in 1 — clock
- `rst_n` in 1 — reset; one clock, reset asynchronous and active-low
- `p_req`, `p_we` in 1 — P access request / write
- `p_addr`, `p_wd` in WIDTH — P address / write data
- `p_stall` out 1 — `p_req & ~p_gnt`; the pipeline freezes MEM
- `p_rvalid`, `p_err` out 1 — P read-data valid / access error
- `p_rdata` out WIDTH — P read data
- `d_req`, `d_we` in 1 — D request / write; held until `d_gnt`
- `d_addr`, `d_wd` in WIDTH — D address / write data
- `d_gnt`, `d_rvalid`, `d_err` out 1 — D grant / read valid / error
- `d_rdata` out WIDTH — D read data
- `io_start` in 1 — single-cycle start pulse from the IO pad synchroniser
- `m_we` out 1 — memory write enable
- `m_a2`, `m_wd` out WIDTH — memory data address / write data
- `m_rd2` in WIDTH — memory read data, valid the cycle after the address
- `startIO` out 1 — sticky start flag, routed to the memory

## Operation
- Arbitration is combinational each cycle. P wins when both request; D wins only when P is idle. Exception: the aging guard (see Configuration).
- The winner's address and write data drive `m_a2`/`m_wd`; `m_we` = winner_we & legal & ~ioflag.
- Address decode:
  - [0,32), [32,1056), [1056,1568): legal, forwarded to memory.
  - RAMSIZE*7: IO flag, handled locally and never forwarded. A read returns {0…, startIO}. A write clears startIO; data is ignored.
  - Any other address: illegal. `m_we` = 0; the access is consumed and reported with `err`.
- Response register (owner, is_read, is_err, is_flag, flag_val) is loaded on every grant:
  - Next cycle, the owner's `rvalid` pulses for reads and `err` pulses for illegal reads or writes.
  - `rdata` = `m_rd2` for legal reads, flag_val for flag reads, 0 on error.
  - The non-owner's `rdata` is 0.
- `startIO` register:
  - Set by `io_start`.
  - Cleared by a granted flag write.
  - Set wins when both occur in the same cycle.
- Back-to-back grants are allowed, with one access per cycle and no bubble.

## Timing
- Reset values: every output is 0, including `startIO`, the response register and the aging counter. Asynchronous assertion clears everything immediately. An access in flight at reset is dropped with no `rvalid`.
- Write: takes effect at the clock edge ending the grant cycle N.
- Read: data returns in N+1. Error: reported in N+1.
- `p_stall`: combinational, in the same cycle as the denial.
- `d_gnt`: combinational. D must hold its request fields stable until granted.
- A P request in N+1 may be granted while the N response is presented.

## Configuration
- `MEM_ARB_AGING_EN` defined:
  - A saturating counter (width $clog2(MAXWAIT+1)) increments each cycle D requests and is denied.
  - When it equals MAXWAIT, D wins over P, and P stalls that cycle.
  - The counter clears on any D grant or when `d_req` = 0.
- `MEM_ARB_AGING_EN` undefined: strict P priority and no counter; D can starve.

## Test plan
- Reset, then P writes 0xDEADBEEF at 40 and reads 40 → `m_we` = 1 in cycle N. `p_rvalid` = 1 and `p_rdata` = 0xDEADBEEF in the read's grant cycle + 1.
- P and D request together for 3 cycles → P granted each cycle, `d_gnt` = 0. P drops → `d_gnt` = 1 the same cycle, `p_stall` = 0 throughout.
- `io_start` pulse, then P reads 7168 → `p_rdata` = 1. P writes 7168 → `startIO` = 0 next cycle, `m_we` stays 0. `io_start` in the same cycle as a flag write → `startIO` = 1.
- D reads 2000 → `m_we` = 0, `d_err` = 1, `d_rvalid` = 1, `d_rdata` = 0 in N+1.
- Aging build, MAXWAIT = 8, P requests continuously, D held → `d_gnt` in the 9th cycle with `p_stall` = 1 there, then P resumes. Non-aging build → D never granted.
- Assert `rst_n` = 0 mid-read → `p_rvalid` is not produced and all outputs are 0 asynchronously.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the segmented memory's data port between the pipeline MEM stage (P) and the IO/DMA engine (D),
// and owns the sticky startIO flag. Define MEM_ARB_AGING_EN to add the D starvation (aging) guard.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int RAMSIZE = 1024
`ifdef MEM_ARB_AGING_EN
    ,
    parameter int MAXWAIT = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p_req_i,
    input  logic             p_we_i,
    input  logic [WIDTH-1:0] p_addr_i,
    input  logic [WIDTH-1:0] p_wd_i,
    output logic             p_stall_o,
    output logic             p_rvalid_o,
    output logic             p_err_o,
    output logic [WIDTH-1:0] p_rdata_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [WIDTH-1:0] d_addr_i,
    input  logic [WIDTH-1:0] d_wd_i,
    output logic             d_gnt_o,
    output logic             d_rvalid_o,
    output logic             d_err_o,
    output logic [WIDTH-1:0] d_rdata_o,
    input  logic             io_start_i,
    output logic             m_we_o,
    output logic [WIDTH-1:0] m_a2_o,
    output logic [WIDTH-1:0] m_wd_o,
    input  logic [WIDTH-1:0] m_rd2_i,
    output logic             startIO_o
);

    localparam logic [WIDTH-1:0] LEGAL_END = WIDTH'(32 + RAMSIZE + RAMSIZE / 2);
    localparam logic [WIDTH-1:0] FLAG_ADDR = WIDTH'(RAMSIZE * 7);

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   is_read;
        logic   is_err;
        logic   is_flag;
        logic   flag_val;
    } resp_t;

    logic             force_d;
    logic             p_gnt;
    logic             d_gnt;
    logic             any_gnt;
    logic             win_we;
    logic [WIDTH-1:0] win_addr;
    logic [WIDTH-1:0] win_wd;
    logic             win_legal;
    logic             win_flag;
    logic             flag_wr;
    resp_t            resp_q, resp_d;
    logic             startio_q, startio_d;
    logic [WIDTH-1:0] rd_val;
    logic             p_owns, d_owns;

    // Grants are qualified by rst_n so the combinational port outputs also read 0 while reset is held.
    assign d_gnt   = rst_n & d_req_i & (~p_req_i | force_d);
    assign p_gnt   = rst_n & p_req_i & ~force_d;
    assign any_gnt = p_gnt | d_gnt;

    assign win_we   = d_gnt ? d_we_i : (p_gnt & p_we_i);
    assign win_addr = d_gnt ? d_addr_i : (p_gnt ? p_addr_i : '0);
    assign win_wd   = d_gnt ? d_wd_i : (p_gnt ? p_wd_i : '0);

    assign win_legal = (win_addr < LEGAL_END);
    assign win_flag  = (win_addr == FLAG_ADDR);
    assign flag_wr   = any_gnt & win_we & win_flag;

    assign m_we_o    = any_gnt & win_we & win_legal & ~win_flag;
    assign m_a2_o    = win_addr;
    assign m_wd_o    = win_wd;
    assign p_stall_o = rst_n & p_req_i & ~p_gnt;
    assign d_gnt_o   = d_gnt;

`ifdef MEM_ARB_AGING_EN
    localparam int AW = $clog2(MAXWAIT + 1);

    logic [AW-1:0] age_q, age_d;

    assign force_d = d_req_i & (age_q == AW'(MAXWAIT));

    // NOTE: every variable assigned in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        age_d = age_q;
        if (!d_req_i || d_gnt) begin
            age_d = '0;
        end else if (age_q != AW'(MAXWAIT)) begin
            age_d = age_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign force_d = 1'b0;
`endif

    always_comb begin
        resp_d = '0;
        if (any_gnt) begin
            resp_d.vld      = 1'b1;
            resp_d.owner    = d_gnt ? OWN_D : OWN_P;
            resp_d.is_read  = ~win_we;
            resp_d.is_flag  = win_flag;
            resp_d.is_err   = ~win_legal & ~win_flag;
            resp_d.flag_val = startio_q;
        end
    end

    // A fresh io_start pulse must never be lost to a simultaneous flag-write clear.
    assign startio_d = io_start_i | (startio_q & ~flag_wr);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q    <= '0;
            startio_q <= 1'b0;
        end else begin
            resp_q    <= resp_d;
            startio_q <= startio_d;
        end
    end

    assign rd_val = resp_q.is_err  ? '0 :
                    resp_q.is_flag ? {{(WIDTH-1){1'b0}}, resp_q.flag_val} :
                                     m_rd2_i;

    assign p_owns = resp_q.vld & (resp_q.owner == OWN_P);
    assign d_owns = resp_q.vld & (resp_q.owner == OWN_D);

    assign p_rvalid_o = p_owns & resp_q.is_read;
    assign p_err_o    = p_owns & resp_q.is_err;
    assign p_rdata_o  = p_rvalid_o ? rd_val : '0;
    assign d_rvalid_o = d_owns & resp_q.is_read;
    assign d_err_o    = d_owns & resp_q.is_err;
    assign d_rdata_o  = d_rvalid_o ? rd_val : '0;
    assign startIO_o  = startio_q;

endmodule
